// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM state definitions for the sequential execute ALU.
// Legal opcodes occupy 0..11; every other 6-bit value is illegal.
package alu_seq_pkg;

  localparam int FUNC_W = 6;

  localparam logic [FUNC_W-1:0] OP_ADD  = 6'd0;
  localparam logic [FUNC_W-1:0] OP_SUB  = 6'd1;
  localparam logic [FUNC_W-1:0] OP_SHR  = 6'd2;
  localparam logic [FUNC_W-1:0] OP_SHL  = 6'd3;
  localparam logic [FUNC_W-1:0] OP_AND  = 6'd4;
  localparam logic [FUNC_W-1:0] OP_OR   = 6'd5;
  localparam logic [FUNC_W-1:0] OP_XOR  = 6'd6;
  localparam logic [FUNC_W-1:0] OP_MV   = 6'd7;
  localparam logic [FUNC_W-1:0] OP_SAR  = 6'd8;
  localparam logic [FUNC_W-1:0] OP_SLT  = 6'd9;
  localparam logic [FUNC_W-1:0] OP_SLTU = 6'd10;
  localparam logic [FUNC_W-1:0] OP_MUL  = 6'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add unsigned multiplier: load on start, WIDTH iterations, done on the last one.
// done and {hi,lo} are valid in the final iteration cycle; start restarts it at any time.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               run;

  // Product is taken from the sum of the final iteration so the caller sees it one cycle earlier.
  always_comb begin
    acc_nxt  = acc + (mplier[0] ? mcand : '0);
    done     = run && (cnt == CW'(WIDTH - 1));
    {hi, lo} = acc_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run    <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (run) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Clocked execute ALU: single-cycle ops give rdy one cycle after start, MUL after WIDTH+1.
// start is taken only in IDLE; busy marks the MUL phase, and start in MUL/DONE is dropped.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 16,
  parameter int MUL_EN    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [FUNC_W-1:0]    func,
  input  logic [WIDTH-1:0]     x1,
  input  logic [WIDTH-1:0]     x2,
  input  logic [IMM_WIDTH-1:0] imm,
  output logic [WIDTH-1:0]     y,
  output logic                 rdy,
  output logic                 busy,
  output logic                 err,
  output logic                 zf,
  output logic                 nf,
  output logic                 cf,
  output logic                 vf
);

  localparam int SHW = $clog2(WIDTH);

  state_t state, state_nxt;
  logic   load_single, load_mul, mul_start, mul_done;
  logic [WIDTH-1:0] mul_lo, mul_hi;

  logic [WIDTH-1:0] res_c;
  logic             cf_c, vf_c, ill_c;
  logic [WIDTH:0]   sum, diff;
  logic [SHW-1:0]   sh;
  logic             big_sh;

  always_comb begin
    state_nxt   = state;
    load_single = 1'b0;
    load_mul    = 1'b0;
    mul_start   = 1'b0;
    busy        = (state == ST_MUL);
    rdy         = (state == ST_DONE);
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (func == OP_MUL && MUL_EN != 0) begin
            mul_start = 1'b1;
            state_nxt = ST_MUL;
          end else begin
            load_single = 1'b1;
            state_nxt   = ST_DONE;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          load_mul  = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Shift amounts use the full x2; anything >= WIDTH saturates.
  always_comb begin
    sum    = {1'b0, x1} + {1'b0, x2};
    diff   = {1'b0, x1} - {1'b0, x2};
    sh     = x2[SHW-1:0];
    big_sh = (x2 >= WIDTH'(WIDTH));
    res_c  = '0;
    cf_c   = 1'b0;
    vf_c   = 1'b0;
    ill_c  = 1'b0;
    case (func)
      OP_ADD: begin
        res_c = sum[WIDTH-1:0];
        cf_c  = sum[WIDTH];
        vf_c  = (x1[WIDTH-1] == x2[WIDTH-1]) && (sum[WIDTH-1] != x1[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = diff[WIDTH-1:0];
        cf_c  = diff[WIDTH];
        vf_c  = (x1[WIDTH-1] != x2[WIDTH-1]) && (diff[WIDTH-1] != x1[WIDTH-1]);
      end
      OP_AND:  res_c = x1 & x2;
      OP_OR:   res_c = x1 | x2;
      OP_XOR:  res_c = x1 ^ x2;
      OP_SHL:  res_c = big_sh ? '0 : (x1 << sh);
      OP_SHR:  res_c = big_sh ? '0 : (x1 >> sh);
      OP_SAR:  res_c = big_sh ? {WIDTH{x1[WIDTH-1]}} : WIDTH'($signed(x1) >>> sh);
      OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, ($signed(x1) < $signed(x2))};
      OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, (x1 < x2)};
      OP_MV:   res_c = WIDTH'(imm);
      // Only reaches the single-cycle path when the multiplier is not built.
      OP_MUL:  ill_c = 1'b1;
      default: ill_c = 1'b1;
    endcase
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (x1),
    .b     (x2),
    .done  (mul_done),
    .lo    (mul_lo),
    .hi    (mul_hi)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      y     <= '0;
      err   <= 1'b0;
      zf    <= 1'b0;
      nf    <= 1'b0;
      cf    <= 1'b0;
      vf    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_single) begin
        err <= ill_c;
        y   <= ill_c ? '0 : res_c;
        zf  <= !ill_c && (res_c == '0);
        nf  <= !ill_c && res_c[WIDTH-1];
        cf  <= !ill_c && cf_c;
        vf  <= !ill_c && vf_c;
      end else if (load_mul) begin
        err <= 1'b0;
        y   <= mul_lo;
        zf  <= (mul_lo == '0);
        nf  <= mul_lo[WIDTH-1];
        cf  <= (mul_hi != '0);
        vf  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Clocked, parametrised successor to the combinational execute ALU.
- Accepts one operation per `start` handshake and returns a registered result with status flags and a `rdy` pulse.
- Adds arithmetic shift, signed/unsigned compare and an iterative shift-add multiply (multi-cycle), with busy/back-pressure signalling.
- Sits in the execute stage between register-file read and write-back, driven by the control FSM.

Parameters:
- WIDTH, 32: operand and result width in bits (≥4, power of two).
- IMM_WIDTH, 16: immediate width; zero-extended to WIDTH for MV.
- MUL_EN, 1: 1 = MUL opcode implemented; 0 = MUL reported as illegal.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- func  input  6  opcode, encodings from shared definitions header.
- x1  input  WIDTH  operand A.
- x2  input  WIDTH  operand B / shift amount.
- imm  input  IMM_WIDTH  immediate for MV.
- y  output  WIDTH  result, held until next completion.
- rdy  output  1  one-cycle pulse: y/flags valid.
- busy  output  1  operation in progress; start ignored.
- err  output  1  with rdy: illegal func.
- zf, nf, cf, vf  output  1 each  zero, negative (y[WIDTH-1]), carry/borrow, signed overflow.

Behaviour:
- Reset (clk edge with rst=1): state=IDLE; y=0, rdy=0, busy=0, err=0, all flags 0. Reset mid-MUL aborts; no rdy is produced.
- States:
  - IDLE: start=1 with single-cycle func → latch and compute → DONE. start=1 with MUL (MUL_EN=1) → latch operands, busy=1 → MUL.
  - MUL: runs exactly WIDTH iterations. Each iteration: if multiplier LSB=1, add multiplicand to accumulator; shift multiplicand left and multiplier right. After the last iteration → DONE.
  - DONE: rdy=1 for exactly one cycle, busy=0, → IDLE.
  - Illegal func → DONE with err=1, y=0, flags=0.
- Latency from the start cycle N:
  - Single-cycle ops: rdy at N+1.
  - MUL: rdy at N+WIDTH+1.
- Throughput:
  - start is accepted in IDLE only. In DONE, start is ignored; it is not queued.
  - busy=1 in MUL only. Single-cycle ops are back-to-back at one per 2 cycles.
- Operations (all mod 2^WIDTH):
  - ADD: x1+x2. cf=carry out. vf=signed overflow.
  - SUB: x1−x2. cf=1 when x1<x2 unsigned (borrow). vf=signed overflow.
  - AND/OR/XOR: bitwise; cf=vf=0.
  - SHL, SHR (logical), SAR (arithmetic): shift amount is the full unsigned x2. Amounts ≥WIDTH give 0 for SHL/SHR and WIDTH copies of x1[WIDTH-1] for SAR. cf=vf=0.
  - SLT: y=1 if signed x1<x2, else 0. SLTU: same, unsigned.
  - MV: y=zero-extended imm.
  - MUL: low WIDTH bits of the unsigned product. cf=1 if the upper WIDTH bits are non-zero. vf=0.
- zf=(y==0) and nf=y[WIDTH-1] for every legal op.
- Inputs are latched at accept; changes to them during MUL have no effect.
- y and flags change only at a rdy cycle or on reset.

Decomposition:
- Shared definitions header holds:
  - Existing opcodes ADD, SUB, SHR, SHL, AND, OR, XOR, MV.
  - New opcodes SAR, SLT, SLTU, MUL.
  - State encodings IDLE/MUL/DONE.
- One sub-module is natural: alu_mul_iter, the shift-add multiplier with start/done, WIDTH-parametrised.
- The FSM, single-cycle datapath and flag logic stay in alu_seq.

Test Plan:
- WIDTH=32. ADD x1=0xFFFFFFFF, x2=1 → next cycle rdy=1, y=0, zf=1, cf=1, vf=0. Then ADD 0x7FFFFFFF+1 → y=0x80000000, nf=1, vf=1.
- SUB 3−5 → y=0xFFFFFFFE, cf=1, nf=1. SLT x1=0xFFFFFFFF, x2=1 → y=1. SLTU with the same operands → y=0.
- SAR x1=0x80000000, x2=4 → y=0xF8000000. SAR by x2=40 → y=0xFFFFFFFF. SHL by x2=32 → y=0, zf=1.
- MUL 0x10000×0x10001 → busy high for 32 cycles, rdy at start+33, y=0x00010000, cf=1. Start pulses during busy are ignored: exactly one rdy.
- Assert rst for one cycle mid-MUL (cycle 10) → next cycle y=0, busy=0, flags=0, no rdy. A following MV imm=0xBEEF → y=0x0000BEEF at start+1.
- Illegal func 0x3F → rdy=1, err=1, y=0. MUL_EN=0 build: MUL → err=1 at start+1.
